// File: rtl/decoder_round_driver_pkg.sv
// Shared definitions for the decoder round driver: controller stage encodings,
// round status codes, driver FSM states and small helper functions.
package decoder_round_driver_pkg;

  // Stage encoding published by the decoder stage controller.
  localparam int STAGE_WIDTH = 3;
  localparam logic [STAGE_WIDTH-1:0] STAGE_IDLE    = 3'd0;
  localparam logic [STAGE_WIDTH-1:0] STAGE_LOADING = 3'd1;
  localparam logic [STAGE_WIDTH-1:0] STAGE_SPREAD  = 3'd2;
  localparam logic [STAGE_WIDTH-1:0] STAGE_SYNC    = 3'd3;
  localparam logic [STAGE_WIDTH-1:0] STAGE_RESULT  = 3'd4;

  // Outcome of one decoding round as reported on m_status.
  typedef logic [1:0] drv_status_t;
  localparam drv_status_t DRV_STATUS_OK       = 2'd0;
  localparam drv_status_t DRV_STATUS_DEADLOCK = 2'd1;
  localparam drv_status_t DRV_STATUS_WDOG     = 2'd2;
  localparam drv_status_t DRV_STATUS_NOACK    = 2'd3;

  // Round sequencer states.
  typedef enum logic [2:0] {
    DRV_IDLE     = 3'd0,
    DRV_START    = 3'd1,
    DRV_WAIT_ACK = 3'd2,
    DRV_RUN      = 3'd3,
    DRV_CAPTURE  = 3'd4,
    DRV_FLUSH    = 3'd5
  } drv_state_e;

  // Number of processing units in the array for the given code distances.
  function automatic int pu_count(input int dx, input int dz);
    return dx * dz * ((dx > dz) ? dx : dz);
  endfunction

  // A stuck controller (no ack or watchdog expiry) must be recovered with a flush.
  function automatic logic status_needs_flush(input drv_status_t s);
    return (s == DRV_STATUS_WDOG) || (s == DRV_STATUS_NOACK);
  endfunction

endpackage

// File: rtl/decoder_round_driver_result_holding_buffer.sv
// Single-entry valid/ready holding register. A new payload may be loaded in the
// same cycle the current one drains, so back-to-back results need no bubble.
module decoder_round_driver_result_holding_buffer
  import decoder_round_driver_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  output logic             can_load,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data
);

  // Free when empty, or when the held entry is being consumed right now.
  assign can_load = !m_valid || m_ready;

  // Hold the payload until consumed; a load wins over a drain in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      m_valid <= 1'b0;
      m_data  <= '0;
    end else if (load && can_load) begin
      m_valid <= 1'b1;
      m_data  <= load_data;
    end else if (m_ready) begin
      m_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/decoder_round_driver.sv
// Host-side round sequencer for the decoder stage controller. Accepts one
// syndrome frame per round, holds it on the PU measurement bus, starts the
// controller, supervises it (ack timeout, watchdog, deadlock) and captures
// the round outcome into a single-entry result buffer. A stuck controller is
// recovered with a fixed-length flush pulse.
module decoder_round_driver
  import decoder_round_driver_pkg::*;
#(
  parameter int  CODE_DISTANCE_X         = 3,
  parameter int  CODE_DISTANCE_Z         = 2,
  parameter int  ITERATION_COUNTER_WIDTH = 8,
  parameter int  ROUND_ID_WIDTH          = 8,
  parameter int  WATCHDOG_CYCLES         = 4096,
  parameter int  ACK_TIMEOUT             = 8,
  parameter int  FLUSH_CYCLES            = 2,
  localparam int PU_COUNT                = pu_count(CODE_DISTANCE_X, CODE_DISTANCE_Z)
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               s_valid,
  output logic                               s_ready,
  input  logic [PU_COUNT-1:0]                s_syndrome,
  output logic [PU_COUNT-1:0]                measurements,
  output logic                               new_round_start,
  output logic                               decoder_flush,
  input  logic [STAGE_WIDTH-1:0]             stage,
  input  logic                               result_valid,
  input  logic                               deadlock,
  input  logic                               final_cardinality,
  input  logic [ITERATION_COUNTER_WIDTH-1:0] iteration_counter,
  input  logic [31:0]                        cycle_counter,
  output logic                               m_valid,
  input  logic                               m_ready,
  output logic [ROUND_ID_WIDTH-1:0]          m_round_id,
  output logic                               m_cardinality,
  output logic [ITERATION_COUNTER_WIDTH-1:0] m_iterations,
  output logic [31:0]                        m_cycles,
  output logic [1:0]                         m_status,
  output logic                               busy
);

  localparam int ACK_W     = $clog2(ACK_TIMEOUT + 1);
  localparam int WDOG_W    = $clog2(WATCHDOG_CYCLES + 1);
  localparam int FLUSH_W   = $clog2(FLUSH_CYCLES + 1);
  localparam int PAYLOAD_W = ROUND_ID_WIDTH + 1 + ITERATION_COUNTER_WIDTH + 32 + 2;

  // Counters start at zero, so the limit is reached while holding LIMIT-1.
  localparam logic [ACK_W-1:0]   ACK_LAST   = ACK_W'(ACK_TIMEOUT - 1);
  localparam logic [WDOG_W-1:0]  WDOG_LAST  = WDOG_W'(WATCHDOG_CYCLES - 1);
  localparam logic [FLUSH_W-1:0] FLUSH_LAST = FLUSH_W'(FLUSH_CYCLES - 1);

  drv_state_e                state, next_state;
  logic [ACK_W-1:0]          ack_cnt, ack_cnt_next;
  logic [WDOG_W-1:0]         wdog_cnt, wdog_cnt_next;
  logic [FLUSH_W-1:0]        flush_cnt, flush_cnt_next;
  drv_status_t               status, status_next;
  logic [ROUND_ID_WIDTH-1:0] round_id;
  logic                      accept;
  logic                      buf_load;
  logic                      buf_can_load;
  logic [PAYLOAD_W-1:0]      buf_load_data;
  logic [PAYLOAD_W-1:0]      buf_data;

  assign accept = s_valid && s_ready;
  assign busy   = (state != DRV_IDLE);

  // Controller counters are sampled in the load cycle; the controller holds
  // them stable once it reports a result or a deadlock.
  assign buf_load_data = {round_id, final_cardinality, iteration_counter, cycle_counter, status};

  // Next-state, counter and result-load decisions for the round sequencer.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path leaves one unassigned and no latch is inferred.
    next_state     = state;
    ack_cnt_next   = ack_cnt;
    wdog_cnt_next  = wdog_cnt;
    flush_cnt_next = flush_cnt;
    status_next    = status;
    buf_load       = 1'b0;

    unique case (state)
      DRV_IDLE: begin
        if (accept) begin
          next_state = DRV_START;
        end
      end

      DRV_START: begin
        next_state   = DRV_WAIT_ACK;
        ack_cnt_next = '0;
      end

      DRV_WAIT_ACK: begin
        if (stage != STAGE_IDLE) begin
          next_state    = DRV_RUN;
          wdog_cnt_next = '0;
        end else if (ack_cnt == ACK_LAST) begin
          status_next = DRV_STATUS_NOACK;
          next_state  = DRV_CAPTURE;
        end else begin
          ack_cnt_next = ack_cnt + ACK_W'(1);
        end
      end

      DRV_RUN: begin
        wdog_cnt_next = wdog_cnt + WDOG_W'(1);
        // Deadlock outranks a result; a result is only trusted once the stage is back to idle.
        if (deadlock) begin
          status_next = DRV_STATUS_DEADLOCK;
          next_state  = DRV_CAPTURE;
        end else if ((stage == STAGE_IDLE) && result_valid) begin
          status_next = DRV_STATUS_OK;
          next_state  = DRV_CAPTURE;
        end else if (wdog_cnt == WDOG_LAST) begin
          status_next = DRV_STATUS_WDOG;
          next_state  = DRV_CAPTURE;
        end
      end

      DRV_CAPTURE: begin
        // Stall without limit until the consumer frees the result buffer.
        if (buf_can_load) begin
          buf_load       = 1'b1;
          flush_cnt_next = '0;
          next_state     = status_needs_flush(status) ? DRV_FLUSH : DRV_IDLE;
        end
      end

      DRV_FLUSH: begin
        if (flush_cnt == FLUSH_LAST) begin
          next_state = DRV_IDLE;
        end else begin
          flush_cnt_next = flush_cnt + FLUSH_W'(1);
        end
      end

      default: begin
        next_state = DRV_IDLE;
      end
    endcase
  end

  // State, counters, round tag, latched frame and registered control outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= DRV_IDLE;
      ack_cnt         <= '0;
      wdog_cnt        <= '0;
      flush_cnt       <= '0;
      status          <= DRV_STATUS_OK;
      round_id        <= '0;
      // NOTE: the measurement register drives the PU array directly, so it is reset like control state rather than left as unreset storage.
      measurements    <= '0;
      new_round_start <= 1'b0;
      decoder_flush   <= 1'b0;
      s_ready         <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
      state     <= next_state;
      ack_cnt   <= ack_cnt_next;
      wdog_cnt  <= wdog_cnt_next;
      flush_cnt <= flush_cnt_next;
      status    <= status_next;
      if (accept) begin
        measurements <= s_syndrome;
      end
      if (buf_load) begin
        round_id <= round_id + ROUND_ID_WIDTH'(1);
      end
      // Outputs registered from the next state so they are glitch-free and line up with it.
      new_round_start <= (next_state == DRV_START);
      decoder_flush   <= (next_state == DRV_FLUSH);
      s_ready         <= (next_state == DRV_IDLE);
    end
  end

  decoder_round_driver_result_holding_buffer #(
    .WIDTH(PAYLOAD_W)
  ) u_result_buffer (
    .clk      (clk),
    .reset    (reset),
    .load     (buf_load),
    .load_data(buf_load_data),
    .can_load (buf_can_load),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (buf_data)
  );

  assign {m_round_id, m_cardinality, m_iterations, m_cycles, m_status} = buf_data;

endmodule

// File: tb/tb_decoder_round_driver.sv
// Self-checking bench for decoder_round_driver: a behavioural controller stub
// reacts to the start pulse per round scenario, and a scoreboard of expected
// results (tag, payload, status) is built from the round rules.
`timescale 1ns/1ps
module tb_decoder_round_driver;
  import decoder_round_driver_pkg::*;

  localparam int CDX  = 3;
  localparam int CDZ  = 2;
  localparam int ITW  = 8;
  localparam int RIW  = 2;
  localparam int WDOG = 64;
  localparam int ACKT = 8;
  localparam int FLC  = 2;
  localparam int PU   = CDX * CDZ * ((CDX > CDZ) ? CDX : CDZ);

  // Round scenarios the controller stub can play.
  localparam int K_OK = 0;  // finishes normally with a result
  localparam int K_DL = 1;  // raises deadlock in SPREAD
  localparam int K_WD = 2;  // gets stuck in SYNC
  localparam int K_NA = 3;  // never leaves IDLE

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 s_valid;
  logic                 s_ready;
  logic [PU-1:0]        s_syndrome;
  logic [PU-1:0]        measurements;
  logic                 new_round_start;
  logic                 decoder_flush;
  logic [STAGE_WIDTH-1:0] stage;
  logic                 result_valid;
  logic                 deadlock;
  logic                 final_cardinality;
  logic [ITW-1:0]       iteration_counter;
  logic [31:0]          cycle_counter;
  logic                 m_valid;
  logic                 m_ready;
  logic [RIW-1:0]       m_round_id;
  logic                 m_cardinality;
  logic [ITW-1:0]       m_iterations;
  logic [31:0]          m_cycles;
  logic [1:0]           m_status;
  logic                 busy;

  always #5 clk = ~clk;

  decoder_round_driver #(
    .CODE_DISTANCE_X        (CDX),
    .CODE_DISTANCE_Z        (CDZ),
    .ITERATION_COUNTER_WIDTH(ITW),
    .ROUND_ID_WIDTH         (RIW),
    .WATCHDOG_CYCLES        (WDOG),
    .ACK_TIMEOUT            (ACKT),
    .FLUSH_CYCLES           (FLC)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .s_valid          (s_valid),
    .s_ready          (s_ready),
    .s_syndrome       (s_syndrome),
    .measurements     (measurements),
    .new_round_start  (new_round_start),
    .decoder_flush    (decoder_flush),
    .stage            (stage),
    .result_valid     (result_valid),
    .deadlock         (deadlock),
    .final_cardinality(final_cardinality),
    .iteration_counter(iteration_counter),
    .cycle_counter    (cycle_counter),
    .m_valid          (m_valid),
    .m_ready          (m_ready),
    .m_round_id       (m_round_id),
    .m_cardinality    (m_cardinality),
    .m_iterations     (m_iterations),
    .m_cycles         (m_cycles),
    .m_status         (m_status),
    .busy             (busy)
  );

  typedef struct {
    int          kind;
    int          len;
    logic        card;
    logic [ITW-1:0] iter;
    logic [31:0] cycles;
  } scen_t;

  typedef struct {
    logic [RIW-1:0] id;
    logic           card;
    logic [ITW-1:0] iter;
    logic [31:0]    cycles;
    logic [1:0]     status;
  } exp_t;

  scen_t scen_q[$];
  exp_t  exp_q[$];

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int rounds_done = 0;
  int pulse_cnt, pulse_cyc, mv_rise_cyc, flush_hi, last_flush_cyc, sr_rise_cyc;
  logic mv_prev = 1'b0;
  logic sr_prev = 1'b0;

  scen_t ctl;
  int    ctl_cnt    = 0;
  bit    ctl_active = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Status a round of each scenario must report: 0 ok, 1 deadlock, 2 watchdog, 3 no ack.
  function automatic logic [1:0] status_of(input int kind);
    case (kind)
      K_OK:    return 2'd0;
      K_DL:    return 2'd1;
      K_WD:    return 2'd2;
      default: return 2'd3;
    endcase
  endfunction

  function automatic scen_t make_scen(input int kind, input int len);
    scen_t s;
    s.kind   = kind;
    s.len    = len;
    s.card   = 1'($urandom_range(0, 1));
    s.iter   = ITW'($urandom);
    s.cycles = $urandom;
    return s;
  endfunction

  task automatic ctl_quiet();
    stage             = STAGE_IDLE;
    result_valid      = 1'b0;
    deadlock          = 1'b0;
    final_cardinality = 1'b0;
    iteration_counter = '0;
    cycle_counter     = '0;
  endtask

  task automatic ctl_finals();
    final_cardinality = ctl.card;
    iteration_counter = ctl.iter;
    cycle_counter     = ctl.cycles;
  endtask

  task automatic ctl_busy_stage();
    stage             = STAGE_WIDTH'(1 + (ctl_cnt % 3));
    iteration_counter = ITW'(ctl_cnt / 3);
    cycle_counter     = 32'(ctl_cnt);
  endtask

  // Controller stub: starts a scenario on the start pulse, then evolves once per cycle.
  task automatic ctl_step();
    if (reset) begin
      ctl_quiet();
      ctl_active = 1'b0;
    end else if (new_round_start) begin
      pulse_cnt++;
      pulse_cyc = cyc;
      if (scen_q.size() == 0) begin
        check("pulse_without_frame", 64'(new_round_start), 64'd0);
      end else begin
        ctl        = scen_q.pop_front();
        ctl_active = 1'b1;
        ctl_cnt    = 0;
        ctl_quiet();
        case (ctl.kind)
          K_OK, K_DL: stage = STAGE_LOADING;
          K_WD: begin stage = STAGE_SYNC; ctl_finals(); end
          default: begin stage = STAGE_IDLE; ctl_finals(); end
        endcase
      end
    end else if (ctl_active) begin
      ctl_cnt++;
      case (ctl.kind)
        K_OK: begin
          if (ctl_cnt >= ctl.len) begin
            stage        = STAGE_IDLE;
            result_valid = 1'b1;
            ctl_finals();
          end else begin
            ctl_busy_stage();
          end
        end
        K_DL: begin
          if (ctl_cnt == ctl.len) begin
            stage    = STAGE_SPREAD;
            deadlock = 1'b1;
            ctl_finals();
          end else if (ctl_cnt > ctl.len) begin
            stage = STAGE_IDLE;
          end else begin
            ctl_busy_stage();
          end
        end
        default: ;
      endcase
    end
  endtask

  // One clock cycle: score a handshake due at this edge, advance, observe #1 after the edge.
  task automatic tick();
    exp_t e;
    if (m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        check("spurious_result", 64'(m_valid), 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("result_id",          64'(m_round_id),    64'(e.id));
        check("result_cardinality", 64'(m_cardinality), 64'(e.card));
        check("result_iterations",  64'(m_iterations),  64'(e.iter));
        check("result_cycles",      64'(m_cycles),      64'(e.cycles));
        check("result_status",      64'(m_status),      64'(e.status));
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    if (m_valid && !mv_prev) mv_rise_cyc = cyc;
    mv_prev = m_valid;
    if (s_ready && !sr_prev) sr_rise_cyc = cyc;
    sr_prev = s_ready;
    if (decoder_flush) begin
      flush_hi++;
      last_flush_cyc = cyc;
    end
    ctl_step();
  endtask

  // Offer a frame, wait for acceptance and queue the result the round must produce.
  task automatic send_frame(input logic [PU-1:0] f, input scen_t s);
    exp_t e;
    int   n = 0;
    scen_q.push_back(s);
    e.id     = RIW'(rounds_done);
    e.card   = s.card;
    e.iter   = s.iter;
    e.cycles = s.cycles;
    e.status = status_of(s.kind);
    exp_q.push_back(e);
    rounds_done++;
    s_syndrome = f;
    s_valid    = 1'b1;
    while (!s_ready && n < 300) begin
      tick();
      n++;
    end
    check("frame_accepted_in_budget", 64'(s_ready), 64'd1);
    tick();
    s_valid    = 1'b0;
    s_syndrome = ~f;
    check("measurements_latched", 64'(measurements), 64'(f));
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!(s_ready && !busy && !m_valid && scen_q.size() == 0 && exp_q.size() == 0) && n < budget) begin
      tick();
      n++;
    end
    check("round_done_in_budget", 64'(n < budget), 64'd1);
  endtask

  task automatic run_round(input string tag, input logic [PU-1:0] f, input scen_t s);
    pulse_cnt   = 0;
    flush_hi    = 0;
    mv_rise_cyc = -1;
    send_frame(f, s);
    wait_done(400);
    check({tag, "_one_start_pulse"},   64'(pulse_cnt), 64'd1);
    check({tag, "_flush_cycles"},      64'(flush_hi),
          (s.kind == K_WD || s.kind == K_NA) ? 64'(FLC) : 64'd0);
    check({tag, "_measurements_hold"}, 64'(measurements), 64'(f));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, observed running expected finished");
    $fatal(1);
  end

  initial begin
    scen_t          s;
    logic [PU-1:0]  fa, fb;
    logic [RIW-1:0] hold_id;
    logic [ITW-1:0] hold_iter;
    logic [31:0]    hold_cycles;
    logic           stable;
    int             n;

    reset      = 1'b1;
    s_valid    = 1'b0;
    s_syndrome = '0;
    m_ready    = 1'b1;
    ctl_quiet();

    // Reset state: every output low.
    repeat (3) tick();
    check("reset_s_ready",         64'(s_ready),         64'd0);
    check("reset_m_valid",         64'(m_valid),         64'd0);
    check("reset_busy",            64'(busy),            64'd0);
    check("reset_new_round_start", 64'(new_round_start), 64'd0);
    check("reset_decoder_flush",   64'(decoder_flush),   64'd0);
    check("reset_measurements",    64'(measurements),    64'd0);
    check("reset_m_round_id",      64'(m_round_id),      64'd0);
    reset = 1'b0;
    tick();
    check("idle_s_ready", 64'(s_ready), 64'd1);

    // Normal round with fixed outcome.
    s.kind = K_OK; s.len = 10; s.card = 1'b1; s.iter = 8'd2; s.cycles = 32'd37;
    run_round("normal", PU'(6'b000011), s);

    // Randomised normal rounds.
    for (int i = 0; i < 4; i++) begin
      run_round("random_ok", PU'($urandom), make_scen(K_OK, int'($urandom_range(3, 30))));
    end

    // Backpressure: two rounds while the consumer is stalled.
    m_ready = 1'b0;
    fa = PU'($urandom);
    fb = PU'($urandom);
    send_frame(fa, make_scen(K_OK, 6));
    n = 0;
    while (!m_valid && n < 200) begin
      tick();
      n++;
    end
    check("bp_first_result_in_budget", 64'(m_valid), 64'd1);
    hold_id     = m_round_id;
    hold_iter   = m_iterations;
    hold_cycles = m_cycles;
    send_frame(fb, make_scen(K_OK, 4));
    stable = 1'b1;
    repeat (20) begin
      tick();
      if (!m_valid || m_round_id !== hold_id || m_iterations !== hold_iter || m_cycles !== hold_cycles)
        stable = 1'b0;
    end
    check("bp_payload_stable",    64'(stable),  64'd1);
    check("bp_second_stalled",    64'(busy),    64'd1);
    check("bp_no_frame_accepted", 64'(s_ready), 64'd0);
    m_ready = 1'b1;
    wait_done(200);
    check("bp_measurements_hold", 64'(measurements), 64'(fb));

    // Deadlock: reported as status 1, no flush, driver ready again.
    run_round("deadlock", PU'($urandom), make_scen(K_DL, 5));
    check("deadlock_ready_after", 64'(s_ready), 64'd1);

    // Watchdog: START, one WAIT_ACK, WDOG RUN cycles, CAPTURE, then the result.
    run_round("watchdog", PU'($urandom), make_scen(K_WD, 0));
    check("watchdog_latency",     64'(mv_rise_cyc - pulse_cyc),    64'(WDOG + 3));
    check("watchdog_ready_after", 64'(sr_rise_cyc - last_flush_cyc), 64'd1);

    // No ack: START, ACKT WAIT_ACK cycles, CAPTURE, then the result.
    run_round("no_ack", PU'($urandom), make_scen(K_NA, 0));
    check("no_ack_latency",     64'(mv_rise_cyc - pulse_cyc),    64'(ACKT + 2));
    check("no_ack_ready_after", 64'(sr_rise_cyc - last_flush_cyc), 64'd1);

    // Reset in the middle of RUN abandons the round.
    send_frame(PU'($urandom), make_scen(K_OK, 40));
    repeat (7) tick();
    check("midrun_busy", 64'(busy), 64'd1);
    reset = 1'b1;
    tick();
    tick();
    check("midrun_reset_m_valid",         64'(m_valid),         64'd0);
    check("midrun_reset_busy",            64'(busy),            64'd0);
    check("midrun_reset_new_round_start", 64'(new_round_start), 64'd0);
    check("midrun_reset_decoder_flush",   64'(decoder_flush),   64'd0);
    check("midrun_reset_measurements",    64'(measurements),    64'd0);
    check("midrun_reset_s_ready",         64'(s_ready),         64'd0);
    exp_q.delete();
    scen_q.delete();
    rounds_done = 0;
    reset       = 1'b0;
    mv_rise_cyc = -1;
    repeat (60) tick();
    check("midrun_no_result", 64'(mv_rise_cyc), 64'(-1));

    // Round tag wrap: five rounds of random kinds carry ids 0,1,2,3,0.
    for (int i = 0; i < 5; i++) begin
      run_round("wrap", PU'($urandom), make_scen(int'($urandom_range(0, 3)), int'($urandom_range(3, 20))));
    end
    check("wrap_rounds_scored", 64'(rounds_done), 64'd5);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/decoder_round_driver.md
Name: decoder_round_driver

Overview:
Host-side sequencer for the decoder stage controller. It accepts one syndrome frame per decoding round over a valid/ready stream and holds it stable on the PU-array measurement bus. It pulses new_round_start, monitors stage, result_valid and deadlock, and captures the round outcome (final cardinality, iteration/cycle counts, error flags) into a single-entry valid/ready result buffer. A watchdog detects a stuck decoder and recovers it with a flush pulse.

Parameters:
CODE_DISTANCE_X, 3, X code distance
CODE_DISTANCE_Z, 2, Z code distance
ITERATION_COUNTER_WIDTH, 8, width of the controller iteration count
ROUND_ID_WIDTH, 8, width of the round tag; wraps modulo 2^ROUND_ID_WIDTH
WATCHDOG_CYCLES, 4096, maximum cycles allowed in RUN
ACK_TIMEOUT, 8, maximum cycles to wait for the stage to leave IDLE after the start pulse
FLUSH_CYCLES, 2, length of the decoder_flush pulse
Derived localparam: PU_COUNT = CODE_DISTANCE_X*CODE_DISTANCE_Z*max(CODE_DISTANCE_X,CODE_DISTANCE_Z)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
s_valid  in  1  syndrome frame valid
s_ready  out  1  driver can accept a frame
s_syndrome  in  PU_COUNT  syndrome bits, one per PU
measurements  out  PU_COUNT  latched syndrome driven to the PU array
new_round_start  out  1  one-cycle start pulse to the controller
decoder_flush  out  1  recovery pulse to the controller/array
stage  in  STAGE_WIDTH  controller stage
result_valid  in  1  controller result ready
deadlock  in  1  controller deadlock flag
final_cardinality  in  1  controller result bit
iteration_counter  in  ITERATION_COUNTER_WIDTH  controller iteration count
cycle_counter  in  32  controller cycle count
m_valid  out  1  result buffer full
m_ready  in  1  consumer accepts the result
m_round_id  out  ROUND_ID_WIDTH  round tag
m_cardinality  out  1  captured final_cardinality
m_iterations  out  ITERATION_COUNTER_WIDTH  captured iteration count
m_cycles  out  32  captured cycle count
m_status  out  2  result status: 0=ok, 1=deadlock, 2=watchdog timeout, 3=ack timeout
busy  out  1  state is not IDLE

Behaviour:
- FSM states: IDLE, START, WAIT_ACK, RUN, CAPTURE, FLUSH.
- Reset values: all outputs 0, measurements 0, round_id 0, state IDLE. Reset mid-round abandons the round with no result; the controller is reset by the same signal.
- IDLE: s_ready=1.
  - On s_valid&&s_ready, latch s_syndrome into measurements and go to START.
  - measurements hold unchanged until the next accepted frame.
- START: new_round_start=1 for exactly one cycle, then go to WAIT_ACK with the ack counter cleared.
- WAIT_ACK:
  - If stage!=STAGE_IDLE, go to RUN with the watchdog cleared.
  - Otherwise increment the ack counter; when it reaches ACK_TIMEOUT, set status=3 and go to CAPTURE.
- RUN: the watchdog increments every cycle. Priority per cycle:
  1. deadlock=1: status=1, go to CAPTURE.
  2. stage==STAGE_IDLE && result_valid=1: status=0, go to CAPTURE.
  3. Watchdog reaches WATCHDOG_CYCLES: status=2, go to CAPTURE.
  - result_valid is ignored while stage!=STAGE_IDLE.
- CAPTURE:
  - Waits while m_valid=1 && !m_ready, holding state; no timeout applies here.
  - When the buffer is free (or drained this same cycle), load round_id, final_cardinality, iteration_counter, cycle_counter and status, then set m_valid.
  - Increment round_id, wrapping at 2^ROUND_ID_WIDTH.
  - Next state is FLUSH if status is 2 or 3, otherwise IDLE.
- FLUSH: decoder_flush=1 for FLUSH_CYCLES cycles, then IDLE.
- Result buffer: m_valid clears on m_valid&&m_ready unless reloaded in the same cycle. Payload is stable while m_valid=1 && !m_ready.
- Sampling: counters are sampled in the CAPTURE load cycle. The controller holds them while result_valid=1 and after a deadlock.
- Registered outputs: new_round_start and decoder_flush are registered. A new frame may be accepted while the previous result is still pending.

Decomposition:
- Shared package: STAGE_WIDTH and the STAGE_* encodings (already shared), plus new constants DRV_STATUS_OK/DEADLOCK/WDOG/NOACK and the driver state encoding.
- Sub-module result_holding_buffer: a single-entry valid/ready register with same-cycle drain-and-load.

Test Plan:
1. Normal round: frame 6'b000011; controller model goes IDLE→LOADING…→IDLE, result_valid=1, final_cardinality=1, iterations=2, cycles=37 → exactly one new_round_start pulse; m_valid with id=0, card=1, iter=2, cycles=37, status=0.
2. Backpressure: two rounds back-to-back with m_ready=0 for 20 cycles → second round stalls in CAPTURE; first payload stable; after m_ready, ids 0 then 1 emitted in order with no loss.
3. Deadlock: model raises deadlock=1 in SPREAD and returns to IDLE with result_valid=0 → status=1, no flush, next frame accepted.
4. Watchdog: WATCHDOG_CYCLES=64, stage stuck at SYNC → status=2 after 64 RUN cycles; decoder_flush high for exactly 2 cycles, then s_ready=1.
5. No ack: stage held at IDLE after the pulse → status=3 after 8 cycles, then flush.
6. Reset mid-RUN and round_id wrap: reset at RUN cycle 5 → all outputs 0, no m_valid. With ROUND_ID_WIDTH=2, after 5 rounds ids read 0,1,2,3,0.
